avalon_st_pkt_fifo: RTL and testbench

Synchronous Avalon-ST packet FIFO placed between an Avalon-ST source (master) and sink (slave), buffering the full beat (data, startofpacket, endofpacket, empty) with ready latency 0 on both sides. It decouples source and sink backpressure and reports fill level and the count of complete packets held. It also flags sink-side framing violations. In the bench it replaces the direct source-to-sink wiring: the source interface drives `in_*` and `out_*` drives the sink interface.

---
 rtl/avalon_st_pkg.sv | 20 ++
 rtl/avalon_st_sync_fifo.sv | 63 ++++++
 rtl/avalon_st_pkt_fifo.sv | 102 ++++++++++
 tb/tb_avalon_st_pkt_fifo.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/avalon_st_pkg.sv
// Shared types for the Avalon-ST packet FIFO: the stored beat layout and the
// framing-tracker states.
package avalon_st_pkg;

  localparam int AVST_DATA_WIDTH  = 32;
  localparam int AVST_EMPTY_WIDTH = 2;

  typedef struct packed {
    logic [AVST_DATA_WIDTH-1:0]  data;
    logic                        startofpacket;
    logic                        endofpacket;
    logic [AVST_EMPTY_WIDTH-1:0] empty;
  } avalon_st_beat_t;

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } avalon_st_frame_state_e;

endpackage

// File: rtl/avalon_st_sync_fifo.sv
// Generic show-ahead synchronous FIFO. push/pop are already-qualified
// handshakes; full/empty come from the fill counter, not pointer compare.
module avalon_st_sync_fifo #(
  parameter  int WIDTH = 37,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic [AW:0]      fill_level,
  output logic             full,
  output logic             empty
);

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   FILL_ONE = (AW+1)'(1);
  localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      fill_q, fill_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   fill_d = fill_q + FILL_ONE;
      2'b01:   fill_d = fill_q - FILL_ONE;
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
    end
  end

  // Storage is deliberately not reset; the fill counter alone says what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data    = mem_q[rd_ptr_q];
  assign fill_level = fill_q;
  assign full       = (fill_q == FULL_LVL);
  assign empty      = (fill_q == '0);

endmodule

// File: rtl/avalon_st_pkt_fifo.sv
// Avalon-ST packet FIFO: buffers whole beats between source and sink, counts
// stored eop beats and flags sop/eop framing violations on the input side.
module avalon_st_pkt_fifo
  import avalon_st_pkg::*;
#(
  parameter  int DATA_WIDTH  = 32,
  parameter  int EMPTY_WIDTH = 2,
  parameter  int DEPTH       = 16,
  localparam int CW          = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic                   in_startofpacket,
  input  logic                   in_endofpacket,
  input  logic [EMPTY_WIDTH-1:0] in_empty,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   out_startofpacket,
  output logic                   out_endofpacket,
  output logic [EMPTY_WIDTH-1:0] out_empty,
  output logic [CW-1:0]          fill_level,
  output logic [CW-1:0]          pkt_count,
  output logic                   err_sop_missing,
  output logic                   err_eop_missing
);

  localparam int            BW      = DATA_WIDTH + 2 + EMPTY_WIDTH;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic          wr_en, rd_en;
  logic          fifo_full, fifo_empty;
  logic [BW-1:0] wr_beat, rd_beat;

  logic [CW-1:0]          pkt_count_q, pkt_count_d;
  avalon_st_frame_state_e frame_state_q, frame_state_d;
  logic                   err_sop_q, err_sop_d;
  logic                   err_eop_q, err_eop_d;

  // Handshakes are masked during reset so nothing moves while state clears.
  assign in_ready  = !reset && !fifo_full;
  assign out_valid = !reset && !fifo_empty;
  assign wr_en     = in_valid && in_ready;
  assign rd_en     = out_valid && out_ready;
  assign wr_beat   = {in_data, in_startofpacket, in_endofpacket, in_empty};
  assign {out_data, out_startofpacket, out_endofpacket, out_empty} = rd_beat;

  avalon_st_sync_fifo #(
    .WIDTH (BW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (wr_en),
    .pop        (rd_en),
    .wr_data    (wr_beat),
    .rd_data    (rd_beat),
    .fill_level (fill_level),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  always_comb begin
    pkt_count_d   = pkt_count_q;
    frame_state_d = frame_state_q;
    err_sop_d     = 1'b0;
    err_eop_d     = 1'b0;
    case ({wr_en && in_endofpacket, rd_en && out_endofpacket})
      2'b10:   pkt_count_d = pkt_count_q + CNT_ONE;
      2'b01:   pkt_count_d = pkt_count_q - CNT_ONE;
      default: pkt_count_d = pkt_count_q;
    endcase
    // Bad beats are still stored; the tracker only reports and resyncs on eop.
    if (wr_en) begin
      if (frame_state_q == IDLE && !in_startofpacket)  err_sop_d = 1'b1;
      if (frame_state_q == IN_PKT && in_startofpacket) err_eop_d = 1'b1;
      frame_state_d = in_endofpacket ? IDLE : IN_PKT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_count_q   <= '0;
      frame_state_q <= IDLE;
      err_sop_q     <= 1'b0;
      err_eop_q     <= 1'b0;
    end else begin
      pkt_count_q   <= pkt_count_d;
      frame_state_q <= frame_state_d;
      err_sop_q     <= err_sop_d;
      err_eop_q     <= err_eop_d;
    end
  end

  assign pkt_count       = pkt_count_q;
  assign err_sop_missing = err_sop_q;
  assign err_eop_missing = err_eop_q;

endmodule

// File: tb/tb_avalon_st_pkt_fifo.sv
// Bench for avalon_st_pkt_fifo: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, and random traffic.
module tb_avalon_st_pkt_fifo;
  import avalon_st_pkg::*;

  localparam int DW    = 32;
  localparam int EW    = 2;
  localparam int DEPTH = 16;
  localparam int CW    = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          in_startofpacket = 1'b0;
  logic          in_endofpacket = 1'b0;
  logic [EW-1:0] in_empty = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_startofpacket;
  logic          out_endofpacket;
  logic [EW-1:0] out_empty;
  logic [CW-1:0] fill_level;
  logic [CW-1:0] pkt_count;
  logic          err_sop_missing;
  logic          err_eop_missing;

  avalon_st_pkt_fifo #(.DATA_WIDTH(DW), .EMPTY_WIDTH(EW), .DEPTH(DEPTH)) dut (
    .clk               (clk),
    .reset             (reset),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_data           (in_data),
    .in_startofpacket  (in_startofpacket),
    .in_endofpacket    (in_endofpacket),
    .in_empty          (in_empty),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_data          (out_data),
    .out_startofpacket (out_startofpacket),
    .out_endofpacket   (out_endofpacket),
    .out_empty         (out_empty),
    .fill_level        (fill_level),
    .pkt_count         (pkt_count),
    .err_sop_missing   (err_sop_missing),
    .err_eop_missing   (err_eop_missing)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  avalon_st_beat_t model_q[$];
  avalon_st_beat_t cap_q[$];
  bit   model_in_pkt = 1'b0;
  logic exp_err_sop = 1'b0;
  logic exp_err_eop = 1'b0;
  int   err_sop_seen = 0;
  int   err_eop_seen = 0;
  int   pkt_peak = 0;
  bit   rand_ready_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of beats plus an in-packet flag, advanced once per cycle.
  always @(negedge clk) begin : compare
    int              eops;
    logic            exp_rdy, exp_vld;
    avalon_st_beat_t nb;
    exp_vld = !reset && (model_q.size() > 0);
    exp_rdy = !reset && (model_q.size() < DEPTH);
    eops = 0;
    foreach (model_q[i]) if (model_q[i].endofpacket) eops++;
    chk("in_ready", in_ready, exp_rdy);
    chk("out_valid", out_valid, exp_vld);
    chk("fill_level", fill_level, model_q.size());
    chk("pkt_count", pkt_count, eops);
    chk("err_sop_missing", err_sop_missing, exp_err_sop);
    chk("err_eop_missing", err_eop_missing, exp_err_eop);
    if (exp_vld)
      chk("out_beat", {out_data, out_startofpacket, out_endofpacket, out_empty}, model_q[0]);
    if (err_sop_missing === 1'b1) err_sop_seen++;
    if (err_eop_missing === 1'b1) err_eop_seen++;
    if (int'(pkt_count) > pkt_peak) pkt_peak = int'(pkt_count);

    exp_err_sop = 1'b0;
    exp_err_eop = 1'b0;
    if (reset) begin
      model_q.delete();
      model_in_pkt = 1'b0;
    end else begin
      if (exp_vld && out_ready) begin
        cap_q.push_back({out_data, out_startofpacket, out_endofpacket, out_empty});
        void'(model_q.pop_front());
      end
      if (exp_rdy && in_valid) begin
        nb = '{data: in_data, startofpacket: in_startofpacket,
               endofpacket: in_endofpacket, empty: in_empty};
        if (!model_in_pkt && !in_startofpacket) exp_err_sop = 1'b1;
        if (model_in_pkt && in_startofpacket)   exp_err_eop = 1'b1;
        model_in_pkt = !in_endofpacket;
        model_q.push_back(nb);
      end
    end
  end

  always @(posedge clk) begin
    if (rand_ready_en) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic s, input logic e,
                           input logic [EW-1:0] em);
    int n;
    bit acc;
    in_valid = 1'b1;
    in_data = d;
    in_startofpacket = s;
    in_endofpacket = e;
    in_empty = em;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 500) begin
      @(negedge clk);
      acc = (in_ready === 1'b1);
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: beat %0h not accepted in %0d cycles", d, n);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (fill_level != '0 && n < 2000) begin
      tick(1);
      n++;
    end
    chk("drain", fill_level, 0);
  endtask

  task automatic clear_logs();
    cap_q.delete();
    err_sop_seen = 0;
    err_eop_seen = 0;
    pkt_peak = 0;
  endtask

  initial begin : watchdog
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int len;
    tick(3);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", in_ready, 1);
    tick(1);

    // Single 4-beat packet straight through.
    clear_logs();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++)
      send_beat(DW'(i + 1), i == 0, i == 3, (i == 3) ? 2'd2 : 2'd0);
    wait_drain();
    chk("t1_count", cap_q.size(), 4);
    for (int i = 0; i < 4 && i < cap_q.size(); i++) begin
      chk("t1_data", cap_q[i].data, i + 1);
      chk("t1_sop", cap_q[i].startofpacket, (i == 0) ? 1 : 0);
      chk("t1_eop", cap_q[i].endofpacket, (i == 3) ? 1 : 0);
      chk("t1_empty", cap_q[i].empty, (i == 3) ? 2 : 0);
    end
    chk("t1_pkt_peak", pkt_peak, 1);
    chk("t1_errs", err_sop_seen + err_eop_seen, 0);

    // Fill to DEPTH with the sink stalled, then stream through a full FIFO.
    clear_logs();
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++)
      send_beat(DW'(32'h100 + i), (i % 4) == 0, (i % 4) == 3, EW'(i));
    @(negedge clk);
    chk("t2_full_level", fill_level, 16);
    chk("t2_full_ready", in_ready, 0);
    chk("t2_full_pkts", pkt_count, 4);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data = 32'h110;
    in_startofpacket = 1'b1;
    in_endofpacket = 1'b0;
    in_empty = 2'd0;
    tick(3);
    out_ready = 1'b1;
    for (int i = 16; i < 24; i++)
      send_beat(DW'(32'h100 + i), (i % 4) == 0, (i % 4) == 3, EW'(i));
    wait_drain();
    chk("t2_count", cap_q.size(), 24);
    for (int i = 0; i < 24 && i < cap_q.size(); i++)
      chk("t2_order", cap_q[i].data, 32'h100 + i);

    // Framing violations: missing eop, then missing sop.
    clear_logs();
    send_beat(32'h200, 1'b1, 1'b0, 2'd0);
    send_beat(32'h201, 1'b1, 1'b1, 2'd1);
    send_beat(32'h202, 1'b0, 1'b1, 2'd3);
    wait_drain();
    tick(2);
    chk("t4_eop_missing_pulses", err_eop_seen, 1);
    chk("t4_sop_missing_pulses", err_sop_seen, 1);
    chk("t4_count", cap_q.size(), 3);
    if (cap_q.size() == 3) begin
      chk("t4_beat0", cap_q[0], {32'h200, 1'b1, 1'b0, 2'd0});
      chk("t4_beat1", cap_q[1], {32'h201, 1'b1, 1'b1, 2'd1});
      chk("t4_beat2", cap_q[2], {32'h202, 1'b0, 1'b1, 2'd3});
    end

    // Random traffic with random sink backpressure.
    rand_ready_en = 1'b1;
    for (int p = 0; p < 1000; p++) begin
      len = $urandom_range(1, 20);
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 1) == 0) tick(1);
        send_beat($urandom, b == 0, b == len - 1, EW'($urandom_range(0, 3)));
      end
    end
    rand_ready_en = 1'b0;
    tick(1);
    out_ready = 1'b1;
    wait_drain();

    // Reset in the middle of a packet with seven beats held.
    clear_logs();
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++)
      send_beat(DW'(32'h300 + i), i == 0, 1'b0, 2'd0);
    @(negedge clk);
    chk("t6_level_before", fill_level, 7);
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    @(negedge clk);
    chk("t6_level", fill_level, 0);
    chk("t6_pkts", pkt_count, 0);
    chk("t6_out_valid", out_valid, 0);
    chk("t6_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++)
      send_beat(DW'(32'h400 + i), i == 0, i == 2, 2'd0);
    wait_drain();
    tick(2);
    chk("t6_errs", err_sop_seen + err_eop_seen, 0);
    chk("t6_count", cap_q.size(), 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
